alu_seq_ctrl: RTL and testbench

Sequential command front-end that drives the combinational 32-bit ALU (a/b/sel in, out back).
- Accepts operation commands over valid/ready and buffers them in a small FIFO.
- Issues one command at a time to the ALU through registered operand/select outputs, then captures the ALU result.
- Returns the result over a valid/ready response channel, with status flags and optional accumulator chaining.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU command front-end.
// The queued command gains a use_acc field only when ACC_CHAIN_EN is defined.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [2:0]           sel;
`ifdef ACC_CHAIN_EN
        logic                 use_acc;
`endif
    } cmd_t;

    function automatic logic is_div_by_zero(input logic [2:0] sel,
                                            input logic [ALU_WIDTH-1:0] b);
        return (sel == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO, DEPTH entries (power of 2); head visible combinationally, one cycle after push.
// Push is ignored when full, pop when empty; no pass-through while full.
module alu_cmd_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_dat,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Queues ALU commands and issues them one at a time; accept-to-rsp_valid is 2 edges, 1 result per 3 cycles.
// rsp_ready low holds the response and stalls issue while the FIFO fills; ACC_CHAIN_EN adds accumulator chaining.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_dz,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    cmd_t             push_cmd;
    cmd_t             head_cmd;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [WIDTH-1:0] issue_a;
    state_t           state;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        push_cmd     = '0;
        push_cmd.a   = cmd_a;
        push_cmd.b   = cmd_b;
        push_cmd.sel = cmd_sel;
`ifdef ACC_CHAIN_EN
        push_cmd.use_acc = cmd_use_acc;
`endif
    end

`ifdef ACC_CHAIN_EN
    logic [WIDTH-1:0] acc;
    assign issue_a = head_cmd.use_acc ? acc : head_cmd.a;
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign issue_a        = head_cmd.a;
`endif

    alu_cmd_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W ($bits(cmd_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // ALU operands only change on issue, so they stay stable through EXEC and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_NOT;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_dz    <= 1'b0;
            rsp_zero  <= 1'b0;
`ifdef ACC_CHAIN_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_a   <= issue_a;
                        alu_b   <= head_cmd.b;
                        alu_sel <= head_cmd.sel;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_dz    <= is_div_by_zero(alu_sel, alu_b);
                    rsp_zero  <= (alu_out == '0);
                    rsp_valid <= 1'b1;
`ifdef ACC_CHAIN_EN
                    acc       <= alu_out;
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: models the external ALU, keeps an in-order scoreboard of expected responses,
// and runs directed cases plus a randomized stream with rsp_ready toggling (works with or without ACC_CHAIN_EN).
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_sel;
    logic        cmd_use_acc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_dz;
    logic        rsp_zero;
    logic        busy;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        logic [31:0] data;
        logic        dz;
        logic        zero;
    } exp_t;

    exp_t        exp_q[$];
    int          outstanding = 0;
    logic [31:0] model_acc   = '0;
    logic        stall_prev  = 1'b0;
    logic [31:0] prev_data;
    logic        prev_dz;
    logic        prev_zero;
    logic        rand_done;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_sel     (cmd_sel),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_dz      (rsp_dz),
        .rsp_zero    (rsp_zero),
        .busy        (busy)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] s);
        case (s)
            3'd0:    return ~a;
            3'd1:    return a | b;
            3'd2:    return a & b;
            3'd3:    return 32'd0 - a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return 32'(a * b);
            default: return (b == 32'd0) ? 32'd0 : a / b;
        endcase
    endfunction

    // External combinational ALU.
    always_comb alu_out = alu_f(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expectations are computed in acceptance order, which is also execution order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            model_acc   = '0;
            stall_prev  = 1'b0;
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, outstanding != 0});
            if (outstanding < DEPTH) chk("cmd_ready_room", {31'd0, cmd_ready}, 32'd1);
            if (outstanding > DEPTH) chk("cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
            if (stall_prev) begin
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_data", rsp_data, prev_data);
                chk("stall_flags", {30'd0, rsp_dz, rsp_zero}, {30'd0, prev_dz, prev_zero});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_data, 32'hdead_beef);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_flags", {30'd0, rsp_dz, rsp_zero}, {30'd0, e.dz, e.zero});
                    outstanding--;
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t        e;
                logic [31:0] a_eff;
`ifdef ACC_CHAIN_EN
                a_eff = cmd_use_acc ? model_acc : cmd_a;
`else
                a_eff = cmd_a;
`endif
                e.data    = alu_f(a_eff, cmd_b, cmd_sel);
                e.dz      = (cmd_sel == 3'b111) && (cmd_b == 32'd0);
                e.zero    = (e.data == 32'd0);
                model_acc = e.data;
                exp_q.push_back(e);
                outstanding++;
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_dz    = rsp_dz;
            prev_zero  = rsp_zero;
        end
    end

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] sel, input logic ua);
        int g = 0;
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_sel     = sel;
        cmd_use_acc = ua;
        @(negedge clk);
        while (!cmd_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) chk("push_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for a response and checks it against literal values; consumes it if rsp_ready is high.
    task automatic expect_rsp(input string name, input logic [31:0] d,
                              input logic dz, input logic z);
        int g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            chk({name, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
        end else begin
            chk({name, "_data"}, rsp_data, d);
            chk({name, "_dz"}, {31'd0, rsp_dz}, {31'd0, dz});
            chk({name, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        @(negedge clk);
        while ((busy || rsp_valid || outstanding != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk({name, "_drain_timeout"}, outstanding, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_sel"}, {29'd0, alu_sel}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_flags"}, {30'd0, rsp_dz, rsp_zero}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_sel     = '0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b1;
        rand_done   = 1'b0;
        #3;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: valid rises two edges after acceptance.
        push_cmd(32'd5, 32'd7, OP_ADD, 1'b0);
        @(negedge clk);
        chk("lat_e0", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e2", {31'd0, rsp_valid}, 32'd1);
        chk("add_data", rsp_data, 32'd12);
        chk("add_flags", {30'd0, rsp_dz, rsp_zero}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle("lat");

        push_cmd(32'd100, 32'd0, OP_DIV, 1'b0);
        push_cmd(32'd9, 32'd9, OP_SUB, 1'b0);
        expect_rsp("div0", 32'd0, 1'b1, 1'b1);
        expect_rsp("sub0", 32'd0, 1'b0, 1'b1);
        wait_idle("flags");

        // Backpressure: one in flight plus DEPTH queued fills the block.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_cmd(i, 10 * i, OP_ADD, 1'b0);
        @(negedge clk);
        chk("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_held_data", rsp_data, 32'd11);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_still_held", rsp_data, 32'd11);
        rsp_ready = 1'b1;
        for (int i = 1; i <= 5; i++) expect_rsp("bp_order", 11 * i, 1'b0, 1'b0);
        wait_idle("bp");

        push_cmd(32'd3, 32'd4, OP_ADD, 1'b0);
        push_cmd(32'd0, 32'd10, OP_ADD, 1'b1);
        expect_rsp("acc_first", 32'd7, 1'b0, 1'b0);
`ifdef ACC_CHAIN_EN
        expect_rsp("acc_chain", 32'd17, 1'b0, 1'b0);
`else
        expect_rsp("acc_ignored", 32'd10, 1'b0, 1'b0);
`endif
        wait_idle("acc");

        // Reset mid-EXEC with two commands queued.
        rsp_ready = 1'b0;
        push_cmd(32'd1, 32'd2, OP_ADD, 1'b0);
        push_cmd(32'd20, 32'd3, OP_ADD, 1'b0);
        push_cmd(32'd30, 32'd3, OP_SUB, 1'b0);
        push_cmd(32'd40, 32'd3, OP_MUL, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("exec_alu_a", alu_a, 32'd20);
        chk("exec_alu_b", alu_b, 32'd3);
        chk("exec_alu_sel", {29'd0, alu_sel}, {29'd0, OP_ADD});
        chk("exec_rsp_data", rsp_data, 32'd3);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        push_cmd(32'd1, 32'd1, OP_ADD, 1'b0);
        expect_rsp("post_rst", 32'd2, 1'b0, 1'b0);
        wait_idle("rst");

        // Randomized stream wrapping the FIFO several times under random backpressure.
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    logic [31:0] ra;
                    logic [31:0] rb;
                    ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 1000);
                    push_cmd(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle("rand");
        chk("rand_all_returned", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
